// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch sequencer and its FIFO.
package fetch_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: parametric synchronous FIFO of fetch entries with push, pop and flush.
// Head is presented straight from storage; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_head = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, reads async imem and queues {pc, instr} toward decode.
// Defining FETCH_PERF_EN adds push and stall counters on io_perf_fetched/io_perf_stalled.
//   state | meaning
//   IDLE  | no fetching; queued entries still drain to decode
//   RUN   | one fetch per cycle while the FIFO has room (or its head leaves)
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = 10,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              io_enable,
  output logic [ADDR_W-1:0] io_imem_addr,
  input  logic [31:0]       io_imem_data,
  input  logic              io_redirect_valid,
  input  logic [31:0]       io_redirect_pc,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [31:0]       io_out_pc,
  output logic [31:0]       io_out_instr,
  output logic              io_misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       io_perf_fetched,
  output logic [31:0]       io_perf_stalled
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic         r_misalign;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;

  assign w_pop       = !w_empty && io_out_ready;
  assign w_push_data = '{pc: r_pc, instr: io_imem_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // A redirect freezes the state and suppresses the fetch for that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    if (!io_redirect_valid) begin
      case (r_state)
        IDLE: if (io_enable) w_state_nxt = RUN;
        RUN: begin
          if (!io_enable) w_state_nxt = IDLE;
          w_push = !w_full || w_pop;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      if (io_redirect_valid) begin
        r_pc <= {io_redirect_pc[31:2], 2'b00};
        if (io_redirect_pc[1:0] != 2'b00) r_misalign <= 1'b1;
      end else if (w_push) begin
        r_pc <= r_pc + INSTR_BYTES;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (io_redirect_valid),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign io_imem_addr = r_pc[ADDR_W+1:2];
  assign io_out_valid = !w_empty;
  assign io_out_pc    = w_head.pc;
  assign io_out_instr = w_head.instr;
  assign io_misalign  = r_misalign;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stalled;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_fetched <= '0;
      r_perf_stalled <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      if ((r_state == RUN) && w_full && !w_pop) r_perf_stalled <= r_perf_stalled + 32'd1;
    end
  end

  assign io_perf_fetched = r_perf_fetched;
  assign io_perf_stalled = r_perf_stalled;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors for fetch_sequencer against an imem where mem[i] = i.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset_n;
  logic        io_enable;
  logic [9:0]  io_imem_addr;
  logic [31:0] io_imem_data;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_pc;
  logic [31:0] io_out_instr;
  logic        io_misalign;
`ifdef FETCH_PERF_EN
  logic [31:0] io_perf_fetched;
  logic [31:0] io_perf_stalled;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .io_enable         (io_enable),
    .io_imem_addr      (io_imem_addr),
    .io_imem_data      (io_imem_data),
    .io_redirect_valid (io_redirect_valid),
    .io_redirect_pc    (io_redirect_pc),
    .io_out_valid      (io_out_valid),
    .io_out_ready      (io_out_ready),
    .io_out_pc         (io_out_pc),
    .io_out_instr      (io_out_instr),
    .io_misalign       (io_misalign)
`ifdef FETCH_PERF_EN
    ,
    .io_perf_fetched   (io_perf_fetched),
    .io_perf_stalled   (io_perf_stalled)
`endif
  );

  // imem model: word i holds value i
  assign io_imem_data = {22'd0, io_imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, ".valid"}, {63'd0, io_out_valid}, 64'd1);
    check({tag, ".pc"},    {32'd0, io_out_pc},    {32'd0, pc});
    check({tag, ".instr"}, {32'd0, io_out_instr}, {32'd0, instr});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n           = 1'b0;
    io_enable         = 1'b0;
    io_out_ready      = 1'b0;
    io_redirect_valid = 1'b0;
    io_redirect_pc    = 32'd0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();
  endtask

  task automatic redirect(input logic [31:0] target);
    io_redirect_valid = 1'b1;
    io_redirect_pc    = target;
    step();
    io_redirect_valid = 1'b0;
    io_redirect_pc    = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state, then streaming one per cycle
    do_reset();
    check("rst.valid",    {63'd0, io_out_valid}, 64'd0);
    check("rst.addr",     {54'd0, io_imem_addr}, 64'd0);
    check("rst.misalign", {63'd0, io_misalign},  64'd0);
    step();
    check("idle.addr",  {54'd0, io_imem_addr}, 64'd0);
    check("idle.valid", {63'd0, io_out_valid}, 64'd0);
    io_enable    = 1'b1;
    io_out_ready = 1'b1;
    step();
    check("run0.valid", {63'd0, io_out_valid}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_head($sformatf("stream%0d", i), 32'(4 * i), 32'(i));
    end

    // 2: back-pressure fills FIFO at 2 entries, pc holds at 8
    do_reset();
    io_enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    check_head("bp.hold", 32'h0, 32'd0);
    check("bp.addr", {54'd0, io_imem_addr}, 64'd2);
    io_out_ready = 1'b1;
    step();
    check_head("bp.r1", 32'h4, 32'd1);
    step();
    check_head("bp.r2", 32'h8, 32'd2);

    // 3: redirect while FIFO is full flushes everything stale
    redirect(32'h100);
    check("redir.flush", {63'd0, io_out_valid}, 64'd0);
    check("redir.addr",  {54'd0, io_imem_addr}, 64'd64);
    step();
    check_head("redir.h0", 32'h100, 32'd64);
    step();
    check_head("redir.h1", 32'h104, 32'd65);
    check("redir.misalign", {63'd0, io_misalign}, 64'd0);

    // 4: misaligned redirect is aligned down and sets the sticky flag
    redirect(32'h102);
    check("mis.flag", {63'd0, io_misalign},  64'd1);
    check("mis.addr", {54'd0, io_imem_addr}, 64'd64);
    step();
    check_head("mis.h0", 32'h100, 32'd64);
    redirect(32'h200);
    step();
    check_head("mis.h1", 32'h200, 32'd128);
    check("mis.sticky", {63'd0, io_misalign}, 64'd1);

    // 5: address wraps at the end of imem while the pc keeps counting
    redirect(32'hFFC);
    check("wrap.addr0", {54'd0, io_imem_addr}, 64'h3FF);
    step();
    check_head("wrap.h0", 32'hFFC, 32'd1023);
    check("wrap.addr1", {54'd0, io_imem_addr}, 64'd0);
    step();
    check_head("wrap.h1", 32'h1000, 32'd0);

    // 6: async reset mid-stream
    check("mid.valid_pre", {63'd0, io_out_valid}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid.valid",    {63'd0, io_out_valid}, 64'd0);
    check("mid.addr",     {54'd0, io_imem_addr}, 64'd0);
    check("mid.misalign", {63'd0, io_misalign},  64'd0);
    #3 reset_n = 1'b1;
    step();
    check("mid.run0", {63'd0, io_out_valid}, 64'd0);
    step();
    check_head("mid.h0", 32'h0, 32'd0);

    // IDLE stops fetching but still drains
    io_out_ready = 1'b0;
    io_enable    = 1'b0;
    step();
    check_head("stop.h0", 32'h0, 32'd0);
    step();
    check("stop.addr", {54'd0, io_imem_addr}, 64'd2);
    io_out_ready = 1'b1;
    step();
    check_head("stop.h1", 32'h4, 32'd1);
    step();
    check("stop.drained", {63'd0, io_out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
